spi_ram_arbiter: RTL and testbench

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_spi_ram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port RAM between SPI slave commands and a local host.
// SPI accesses go through a one-entry pending slot; ties go to the side not granted last.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  output logic                 spi_ovf
);

  typedef enum logic [1:0] {IDLE, GRANT_SPI, GRANT_HOST, RD_WAIT} state_t;

  state_t               state, state_nxt;
  logic                 rx_prev, rx_edge, post, slot_free;
  logic [ADDR_SIZE-1:0] rx_addr, wr_addr, rd_addr, pend_addr;
  logic [MEM_WIDTH-1:0] rx_byte, pend_data;
  logic                 pend_valid, pend_we;
  logic                 last_host;
  logic                 rd_host;

  // Opcode bit 8 marks a RAM-posting command; bit 9 selects the read side.
  assign rx_edge   = rx_valid & ~rx_prev;
  assign post      = rx_edge & rx_data[8];
  assign slot_free = ~pend_valid | (state == GRANT_SPI);
  assign rx_addr   = ADDR_SIZE'(rx_data[7:0]);
  assign rx_byte   = MEM_WIDTH'(rx_data[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_prev     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      pend_valid  <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      spi_ovf     <= 1'b0;
      last_host   <= 1'b1;
      rd_host     <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_prev <= rx_valid;

      if (rx_edge && !rx_data[8]) begin
        if (rx_data[9]) rd_addr <= rx_addr;
        else            wr_addr <= rx_addr;
      end

      // A slot being granted this cycle frees up in time to take the new command.
      if (post && slot_free) begin
        pend_valid <= 1'b1;
        pend_we    <= ~rx_data[9];
        pend_addr  <= rx_data[9] ? rd_addr : wr_addr;
        pend_data  <= rx_byte;
      end else if (state == GRANT_SPI) begin
        pend_valid <= 1'b0;
      end

      if (post && !slot_free) spi_ovf <= 1'b1;

      if (state == GRANT_SPI) begin
        last_host <= 1'b0;
        rd_host   <= 1'b0;
      end else if (state == GRANT_HOST) begin
        last_host <= 1'b1;
        rd_host   <= 1'b1;
      end

      host_rvalid <= (state == RD_WAIT) && rd_host;
      if (state == RD_WAIT && rd_host) host_rdata <= ram_dout;

      if (state == RD_WAIT && !rd_host) begin
        tx_data  <= ram_dout;
        tx_valid <= 1'b1;
      end else if (rx_edge) begin
        tx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    host_gnt  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    unique case (state)
      IDLE: begin
        if (pend_valid && (!host_req || last_host)) state_nxt = GRANT_SPI;
        else if (host_req)                          state_nxt = GRANT_HOST;
      end
      GRANT_SPI: begin
        ram_en    = 1'b1;
        ram_we    = pend_we;
        ram_addr  = pend_addr;
        ram_din   = pend_data;
        state_nxt = pend_we ? IDLE : RD_WAIT;
      end
      GRANT_HOST: begin
        host_gnt  = 1'b1;
        ram_en    = 1'b1;
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_din   = host_wdata;
        state_nxt = host_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: behavioural RAM, transaction-level
// reference model (memory array + SPI address registers), directed and random traffic.
module tb_spi_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          spi_ovf;

  int checks = 0;
  int passed = 0;
  int we_pulses = 0;
  int host_gnts = 0;
  int rvalid_pulses = 0;

  logic [DW-1:0] ram [256];
  logic [DW-1:0] ref_mem [256];
  logic [7:0]    m_wr_addr, m_rd_addr;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_SIZE(AW), .MEM_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .spi_ovf(spi_ovf)
  );

  // Single-port RAM with one-cycle read latency; cleared while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_en && ram_we) we_pulses++;
    if (host_gnt) host_gnts++;
    if (host_rvalid) rvalid_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr_addr = '0;
    m_rd_addr = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Reference: what an accepted SPI word means at the transaction level.
  task automatic model_spi(input logic [9:0] w, output logic is_read, output logic [7:0] exp);
    is_read = 1'b0;
    exp = '0;
    case (w[9:8])
      2'b00: m_wr_addr = w[7:0];
      2'b01: ref_mem[m_wr_addr] = w[7:0];
      2'b10: m_rd_addr = w[7:0];
      default: begin is_read = 1'b1; exp = ref_mem[m_rd_addr]; end
    endcase
  endtask

  task automatic spi_word(input logic [9:0] w, input int hold);
    rx_data = w;
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
  endtask

  task automatic spi_run(input logic [9:0] w, input string tag);
    logic rd;
    logic [7:0] exp;
    int base, lat;
    model_spi(w, rd, exp);
    base = we_pulses;
    spi_word(w, 1);
    lat = 1;
    while (rd && !tx_valid && lat < 12) begin tick(); lat++; end
    if (rd) begin
      checks++;
      if (lat !== 4 || tx_valid !== 1'b1)
        $display("FAIL %s_latency: tx_valid=%b after %0d cycles, expected 1 after 4", tag, tx_valid, lat);
      else passed++;
      checks++;
      if (tx_data !== exp) $display("FAIL %s_data: tx_data=%h expected %h", tag, tx_data, exp);
      else passed++;
    end
    repeat (5) tick();
    checks++;
    if (we_pulses - base !== ((w[9:8] == 2'b01) ? 1 : 0))
      $display("FAIL %s_writes: ram writes=%0d expected %0d", tag, we_pulses - base, (w[9:8] == 2'b01) ? 1 : 0);
    else passed++;
  endtask

  task automatic host_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input string tag);
    int base_g, base_r, n;
    logic [7:0] exp;
    base_g = host_gnts;
    base_r = rvalid_pulses;
    exp = ref_mem[addr];
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    tick();
    n = 1;
    while (!host_gnt && n < 12) begin tick(); n++; end
    checks++;
    if (host_gnt !== 1'b1) $display("FAIL %s_gnt: host_gnt=%b after %0d cycles, expected 1", tag, host_gnt, n);
    else passed++;
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, we, addr})
      $display("FAIL %s_ram: en/we/addr=%b/%b/%h expected 1/%b/%h", tag, ram_en, ram_we, ram_addr, we, addr);
    else passed++;
    if (we) begin
      checks++;
      if (ram_din !== wdata) $display("FAIL %s_din: ram_din=%h expected %h", tag, ram_din, wdata);
      else passed++;
    end
    host_req = 1'b0;
    if (we) begin
      ref_mem[addr] = wdata;
    end else begin
      tick();
      checks++;
      if (host_rvalid !== 1'b0) $display("FAIL %s_rvalid_early: host_rvalid=%b expected 0", tag, host_rvalid);
      else passed++;
      tick();
      checks++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp)
        $display("FAIL %s_rdata: rvalid=%b rdata=%h expected 1/%h", tag, host_rvalid, host_rdata, exp);
      else passed++;
    end
    repeat (3) tick();
    checks++;
    if (host_gnts - base_g !== 1 || rvalid_pulses - base_r !== (we ? 0 : 1))
      $display("FAIL %s_pulses: gnt=%0d rvalid=%0d expected 1/%0d", tag, host_gnts - base_g,
               rvalid_pulses - base_r, we ? 0 : 1);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({tx_valid, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf, tx_data, host_rdata, ram_addr, ram_din} !== '0)
        $display("FAIL reset_outputs: tx_valid=%b gnt=%b rvalid=%b en=%b we=%b ovf=%b tx=%h hr=%h a=%h d=%h expected all 0",
                 tx_valid, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf, tx_data, host_rdata, ram_addr, ram_din);
      else passed++;
      tick();
    end
  endtask

  task automatic test_spi_directed();
    spi_run({2'b00, 8'h12}, "dir_wa");
    spi_run({2'b01, 8'hA5}, "dir_wr");
    spi_run({2'b10, 8'h12}, "dir_ra");
    spi_run({2'b11, 8'h3F}, "dir_rd");
    checks++;
    if (ram[8'h12] !== 8'hA5) $display("FAIL dir_ram: ram[12]=%h expected a5", ram[8'h12]);
    else passed++;
    checks++;
    if (tx_valid !== 1'b1) $display("FAIL tx_hold: tx_valid=%b expected 1", tx_valid);
    else passed++;
    spi_run({2'b00, 8'h05}, "dir_clr");
    checks++;
    if (tx_valid !== 1'b0) $display("FAIL tx_clear: tx_valid=%b expected 0", tx_valid);
    else passed++;
  endtask

  task automatic test_held_valid();
    int base;
    logic rd;
    logic [7:0] exp;
    base = we_pulses;
    model_spi({2'b01, 8'h9C}, rd, exp);
    spi_word({2'b01, 8'h9C}, 5);
    repeat (6) tick();
    checks++;
    if (we_pulses - base !== 1) $display("FAIL held_valid: ram writes=%0d expected 1", we_pulses - base);
    else passed++;
    checks++;
    if (ram[m_wr_addr] !== 8'h9C) $display("FAIL held_ram: ram=%h expected 9c", ram[m_wr_addr]);
    else passed++;
  endtask

  task automatic test_random_spi();
    logic [1:0] op;
    logic [7:0] pl;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      pl = op[0] ? 8'($urandom) : 8'($urandom_range(0, 7));
      spi_run({op, pl}, "rnd_spi");
    end
  endtask

  task automatic test_host();
    host_access(1'b1, 8'h07, 8'h3C, "host_wr");
    host_access(1'b0, 8'h07, 8'h00, "host_rd");
    checks++;
    if (host_rdata !== 8'h3C) $display("FAIL host_rdata_hold: host_rdata=%h expected 3c", host_rdata);
    else passed++;
  endtask

  task automatic test_random_host();
    for (int i = 0; i < 16; i++)
      host_access(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), "rnd_host");
  endtask

  task automatic tie_order(input logic [7:0] spi_d, input logic [7:0] h_addr, input logic [7:0] h_d,
                           output string order);
    order = "";
    spi_word({2'b01, spi_d}, 1);
    host_req = 1'b1; host_we = 1'b1; host_addr = h_addr; host_wdata = h_d;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (host_gnt) begin order = {order, "H"}; host_req = 1'b0; end
      else if (ram_en) order = {order, "S"};
    end
    host_req = 1'b0;
    ref_mem[m_wr_addr] = spi_d;
    ref_mem[h_addr] = h_d;
  endtask

  task automatic test_tie();
    string order;
    do_reset();
    spi_run({2'b00, 8'h20}, "tie_wa");
    tie_order(8'h55, 8'h21, 8'h66, order);
    checks++;
    if (order != "SH") $display("FAIL tie_first: order=%s expected SH", order);
    else passed++;
    spi_run({2'b01, 8'h77}, "tie_spi_only");
    tie_order(8'h88, 8'h22, 8'h99, order);
    checks++;
    if (order != "HS") $display("FAIL tie_repeat: order=%s expected HS", order);
    else passed++;
    checks++;
    if ({ram[8'h20], ram[8'h21], ram[8'h22]} !== {ref_mem[8'h20], ref_mem[8'h21], ref_mem[8'h22]})
      $display("FAIL tie_ram: ram=%h/%h/%h expected %h/%h/%h", ram[8'h20], ram[8'h21], ram[8'h22],
               ref_mem[8'h20], ref_mem[8'h21], ref_mem[8'h22]);
    else passed++;
  endtask

  task automatic test_overflow();
    int base;
    base = we_pulses;
    spi_run({2'b00, 8'h30}, "ovf_wa");
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21;
    rx_data = {2'b01, 8'h11}; rx_valid = 1'b1;
    tick();
    checks++;
    if (host_gnt !== 1'b1) $display("FAIL ovf_gnt: host_gnt=%b expected 1", host_gnt);
    else passed++;
    host_req = 1'b0; rx_valid = 1'b0;
    tick();
    rx_data = {2'b01, 8'h22}; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (spi_ovf !== 1'b1) $display("FAIL ovf_flag: spi_ovf=%b expected 1", spi_ovf);
    else passed++;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[8'h21])
      $display("FAIL ovf_host_rd: rvalid=%b rdata=%h expected 1/%h", host_rvalid, host_rdata, ref_mem[8'h21]);
    else passed++;
    repeat (6) tick();
    ref_mem[8'h30] = 8'h11;
    checks++;
    if (we_pulses - base !== 1) $display("FAIL ovf_writes: ram writes=%0d expected 1", we_pulses - base);
    else passed++;
    checks++;
    if (ram[8'h30] !== 8'h11) $display("FAIL ovf_ram: ram[30]=%h expected 11", ram[8'h30]);
    else passed++;
    spi_run({2'b10, 8'h30}, "ovf_ra");
    checks++;
    if (spi_ovf !== 1'b1) $display("FAIL ovf_sticky: spi_ovf=%b expected 1", spi_ovf);
    else passed++;
  endtask

  task automatic test_reset_abort();
    spi_word({2'b11, 8'h00}, 1);
    tick();
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h30})
      $display("FAIL abort_grant: en/we/addr=%b/%b/%h expected 1/0/30", ram_en, ram_we, ram_addr);
    else passed++;
    tick();
    checks++;
    if (ram_en !== 1'b0) $display("FAIL abort_rdwait_en: ram_en=%b expected 0", ram_en);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    checks++;
    if ({tx_valid, ram_en, host_gnt, host_rvalid, spi_ovf} !== 5'b0)
      $display("FAIL abort_outputs: tx_valid=%b en=%b gnt=%b rvalid=%b ovf=%b expected 0",
               tx_valid, ram_en, host_gnt, host_rvalid, spi_ovf);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b0 || ram_en !== 1'b0)
        $display("FAIL abort_quiet: tx_valid=%b ram_en=%b expected 0/0", tx_valid, ram_en);
      else passed++;
    end
    host_access(1'b0, 8'h30, 8'h00, "abort_host");
  endtask

  initial begin
    test_reset();
    test_spi_directed();
    test_held_valid();
    test_random_spi();
    test_host();
    test_random_host();
    test_tie();
    test_overflow();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
